// File: rtl/gaus_win_ctrl.sv
// gaus_win_ctrl
//
// Evaluates a full 7x7 Gaussian window by streaming its seven pixel/kernel
// row pairs through one shared 7-tap line dot-product unit. The seven line
// results are summed, rounded, shifted down by SHIFT and saturated to an
// 8-bit filtered pixel.
//
// Ports:
//   clk, rst               rising-edge clock, asynchronous active-high reset
//   win_valid/win_ready    window + kernel handshake (one window in flight)
//   win_data, coef_data    7 rows x 7 bytes; row i = [56*i+55:56*i]
//   line_start             one start pulse per row issued to the line unit
//   line_a, line_b         pixel row / kernel row for the line unit
//   line_result            line unit result (unsigned, mod 2^16)
//   line_finish            line_result valid this cycle
//   out_valid/out_ready    filtered pixel handshake
//   out_data               filtered pixel
//   err                    sticky protocol error (unexpected line_finish)
module gaus_win_ctrl #(
  parameter int SHIFT = 8,
  parameter int LAT   = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         win_valid,
  output logic         win_ready,
  input  logic [391:0] win_data,
  input  logic [391:0] coef_data,
  output logic         line_start,
  output logic [55:0]  line_a,
  output logic [55:0]  line_b,
  input  logic [15:0]  line_result,
  input  logic         line_finish,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_data,
  output logic         err
);

  localparam logic [2:0] S_DRAIN = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  // Drain lasts LAT+1 cycles: counter runs 0..LAT.
  localparam logic [7:0]  DRAIN_LAST = 8'(LAT);
  // Half an output LSB; written so SHIFT=0 yields zero without a negative shift.
  localparam logic [19:0] RND = (20'd1 << SHIFT) >> 1;

  logic [2:0]   state;
  logic [7:0]   drain_cnt;
  logic [2:0]   row_cnt;
  logic [2:0]   fin_cnt;
  logic [18:0]  acc_p1;
  logic [18:0]  acc_sum;
  logic [335:0] win_p0;
  logic [335:0] coef_p0;

  // Round half up, normalise by the kernel sum, clamp to 8 bits.
  function automatic logic [7:0] round_sat(input logic [18:0] sum);
    logic [19:0] wide;
    wide = ({1'b0, sum} + RND) >> SHIFT;
    if (wide > 20'd255) return 8'hFF;
    return wide[7:0];
  endfunction

  // 7 x 65535 fits in 19 bits, so the running sum never wraps.
  assign acc_sum = acc_p1 + {3'b000, line_result};

  // ---- stage 0: window capture (row 0 goes straight to the line unit) ----
  always_ff @(posedge clk) begin
    if (state == S_IDLE && win_valid) begin
      win_p0  <= win_data[391:56];
      coef_p0 <= coef_data[391:56];
    end
  end

  // ---- stage 1: row issue, result collection, normalisation ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_DRAIN;
      drain_cnt  <= 8'd0;
      row_cnt    <= 3'd0;
      fin_cnt    <= 3'd0;
      acc_p1     <= 19'd0;
      win_ready  <= 1'b0;
      line_start <= 1'b0;
      line_a     <= 56'd0;
      line_b     <= 56'd0;
      out_valid  <= 1'b0;
      out_data   <= 8'd0;
      err        <= 1'b0;
    end else begin
      case (state)
        // The line unit has no reset; let anything in flight fall out first.
        S_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state     <= S_IDLE;
            win_ready <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 8'd1;
          end
        end

        S_IDLE: begin
          if (line_finish) err <= 1'b1;
          if (win_valid) begin
            win_ready  <= 1'b0;
            acc_p1     <= 19'd0;
            fin_cnt    <= 3'd0;
            row_cnt    <= 3'd1;
            line_start <= 1'b1;
            line_a     <= win_data[55:0];
            line_b     <= coef_data[55:0];
            state      <= S_ISSUE;
          end
        end

        S_ISSUE, S_WAIT: begin
          if (state == S_ISSUE) begin
            if (row_cnt == 3'd7) begin
              line_start <= 1'b0;
              state      <= S_WAIT;
            end else begin
              line_a  <= win_p0[(int'(row_cnt) - 1) * 56 +: 56];
              line_b  <= coef_p0[(int'(row_cnt) - 1) * 56 +: 56];
              row_cnt <= row_cnt + 3'd1;
            end
          end
          // Completion is counted in finishes, so line-unit latency is free
          // to vary. A surplus finish can only land in OUT/IDLE and flags err.
          if (line_finish) begin
            acc_p1  <= acc_sum;
            fin_cnt <= fin_cnt + 3'd1;
            if (fin_cnt == 3'd6) begin
              line_start <= 1'b0;
              out_valid  <= 1'b1;
              out_data   <= round_sat(acc_sum);
              state      <= S_OUT;
            end
          end
        end

        S_OUT: begin
          if (line_finish) err <= 1'b1;
          if (out_ready) begin
            out_valid <= 1'b0;
            win_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: begin
          state     <= S_DRAIN;
          drain_cnt <= 8'd0;
          win_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gaus_win_ctrl.sv
// Testbench for gaus_win_ctrl: contains a behavioural 5-cycle line unit,
// a table of uniform windows with hand-computed results, marker/random
// windows checked against an arithmetic reference, and hand-written reset,
// back-pressure and error sequences.
module tb_gaus_win_ctrl;

  localparam int SHIFT = 8;
  localparam int LAT   = 5;

  logic         clk;
  logic         rst;
  logic         win_valid;
  logic         win_ready;
  logic [391:0] win_data;
  logic [391:0] coef_data;
  logic         line_start;
  logic [55:0]  line_a;
  logic [55:0]  line_b;
  logic [15:0]  line_result;
  logic         line_finish;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_data;
  logic         err;

  gaus_win_ctrl #(.SHIFT(SHIFT), .LAT(LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .win_valid   (win_valid),
    .win_ready   (win_ready),
    .win_data    (win_data),
    .coef_data   (coef_data),
    .line_start  (line_start),
    .line_a      (line_a),
    .line_b      (line_b),
    .line_result (line_result),
    .line_finish (line_finish),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Line unit: dot product of a row pair, result after LAT cycles, no reset.
  function automatic logic [15:0] dot7(input logic [55:0] a, input logic [55:0] b);
    int s;
    s = 0;
    for (int j = 0; j < 7; j++) s += int'(a[8*j +: 8]) * int'(b[8*j +: 8]);
    return 16'(s);
  endfunction

  logic        pipe_v [LAT];
  logic [15:0] pipe_r [LAT];
  logic        inj;

  always_ff @(posedge clk) begin
    pipe_v[0] <= line_start;
    pipe_r[0] <= dot7(line_a, line_b);
    for (int i = 1; i < LAT; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_r[i] <= pipe_r[i-1];
    end
  end

  assign line_finish = pipe_v[LAT-1] | inj;
  assign line_result = inj ? 16'hABCD : pipe_r[LAT-1];

  int n_tests;
  int n_fail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [55:0] row_of(input logic [391:0] w, input int r);
    return w[r*56 +: 56];
  endfunction

  // Reference: each row sum wraps mod 2^16, rows add exactly, then
  // round-half-up division by 2^SHIFT and clamp at 255.
  function automatic logic [7:0] ref_out(input logic [391:0] w, input logic [391:0] c);
    longint acc, row, v;
    acc = 0;
    for (int r = 0; r < 7; r++) begin
      row = 0;
      for (int j = 0; j < 7; j++)
        row += longint'(w[56*r + 8*j +: 8]) * longint'(c[56*r + 8*j +: 8]);
      acc += row % 65536;
    end
    if (SHIFT > 0) v = (acc + (longint'(1) << (SHIFT - 1))) / (longint'(1) << SHIFT);
    else           v = acc;
    return (v > 255) ? 8'd255 : 8'(v);
  endfunction

  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    while (!win_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!win_ready) chk({tag, "_ready_timeout"}, 64'(win_ready), 64'd1);
  endtask

  // Counts cycles with win_ready low, starting from the current (release) cycle.
  task automatic drain_count(input string tag);
    int k;
    k = 0;
    while (!win_ready && k < 50) begin
      k++;
      @(negedge clk);
    end
    chk({tag, "_drain_len"}, 64'(k), 64'd6);
  endtask

  task automatic do_window(input logic [391:0] w, input logic [391:0] c,
                           input logic [7:0] exp_out, input logic exp_err,
                           input int hold, input bit inject_out, input string tag);
    int n, starts, bad_row, unstable;
    wait_ready(tag);
    win_data  = w;
    coef_data = c;
    win_valid = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    win_valid = 1'b0;
    win_data  = '0;
    coef_data = '0;
    n = 1; starts = 0; bad_row = 0;
    while (!out_valid && n < 60) begin
      if (line_start) begin
        starts++;
        if (n < 1 || n > 7) bad_row++;
        else if (line_a !== row_of(w, n-1) || line_b !== row_of(c, n-1)) bad_row++;
      end
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'd13);
    chk({tag, "_starts"}, 64'(starts), 64'd7);
    chk({tag, "_row_order"}, 64'(bad_row), 64'd0);
    chk({tag, "_out_data"}, 64'(out_data), 64'(exp_out));
    unstable = 0;
    for (int h = 0; h < hold; h++) begin
      if (inject_out && h == 2) inj = 1'b1;
      if (h == 3) inj = 1'b0;
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== exp_out || win_ready !== 1'b0 ||
          line_start !== 1'b0) unstable++;
    end
    inj = 1'b0;
    if (hold > 0) chk({tag, "_hold_stable"}, 64'(unstable), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
    chk({tag, "_idle_ready"}, 64'(win_ready), 64'd1);
    chk({tag, "_err"}, 64'(err), 64'(exp_err));
  endtask

  typedef struct {
    logic [7:0] pix;
    logic [7:0] coef;
    int         hold;
    logic [7:0] exp_out;
  } vec_t;

  vec_t tbl [7];

  initial begin
    logic [391:0] w, c;
    n_tests = 0;
    n_fail  = 0;

    tbl[0] = '{8'd16,  8'd16,  0,  8'd49};
    tbl[1] = '{8'd255, 8'd255, 0,  8'd255};
    tbl[2] = '{8'd10,  8'd20,  10, 8'd38};
    tbl[3] = '{8'd4,   8'd8,   0,  8'd6};
    tbl[4] = '{8'd1,   8'd1,   0,  8'd0};
    tbl[5] = '{8'd2,   8'd2,   3,  8'd1};
    tbl[6] = '{8'd0,   8'd0,   0,  8'd0};

    rst = 1'b1; win_valid = 1'b0; out_ready = 1'b0; inj = 1'b0;
    win_data = '0; coef_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_win_ready",  64'(win_ready),  64'd0);
    chk("rst_out_valid",  64'(out_valid),  64'd0);
    chk("rst_out_data",   64'(out_data),   64'd0);
    chk("rst_line_start", 64'(line_start), 64'd0);
    chk("rst_line_a",     64'(line_a),     64'd0);
    chk("rst_line_b",     64'(line_b),     64'd0);
    chk("rst_err",        64'(err),        64'd0);
    rst = 1'b0;
    drain_count("init");

    // Uniform windows with hand-computed results.
    for (int i = 0; i < 7; i++)
      do_window({49{tbl[i].pix}}, {49{tbl[i].coef}}, tbl[i].exp_out, 1'b0,
                tbl[i].hold, 1'b0, $sformatf("tbl%0d", i));

    // Distinct per-row markers so row order is visible on line_a/line_b.
    for (int r = 0; r < 7; r++)
      for (int j = 0; j < 7; j++) begin
        w[56*r + 8*j +: 8] = 8'(16*r + j + 1);
        c[56*r + 8*j +: 8] = 8'(r + 1);
      end
    do_window(w, c, ref_out(w, c), 1'b0, 0, 1'b0, "marker");

    // Random windows over three magnitude ranges.
    for (int i = 0; i < 12; i++) begin
      for (int b = 0; b < 49; b++) begin
        case (i % 3)
          0: begin w[8*b +: 8] = 8'($urandom); c[8*b +: 8] = 8'($urandom_range(0, 8)); end
          1: begin w[8*b +: 8] = 8'($urandom_range(0, 40)); c[8*b +: 8] = 8'($urandom_range(0, 40)); end
          default: begin w[8*b +: 8] = 8'($urandom); c[8*b +: 8] = 8'($urandom); end
        endcase
      end
      do_window(w, c, ref_out(w, c), 1'b0, $urandom_range(0, 3), 1'b0,
                $sformatf("rnd%0d", i));
    end

    // Reset in cycle 8 of a window: abort, drain stale finishes.
    wait_ready("midrst");
    win_data = {49{8'd16}}; coef_data = {49{8'd16}}; win_valid = 1'b1;
    @(negedge clk);
    win_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid",  64'(out_valid),  64'd0);
    chk("midrst_line_start", 64'(line_start), 64'd0);
    chk("midrst_line_a",     64'(line_a),     64'd0);
    chk("midrst_win_ready",  64'(win_ready),  64'd0);
    @(negedge clk);
    rst = 1'b0;
    drain_count("midrst");
    repeat (3) @(negedge clk);
    chk("midrst_no_out", 64'(out_valid), 64'd0);
    chk("midrst_err",    64'(err),       64'd0);
    do_window({49{8'd16}}, {49{8'd16}}, 8'd49, 1'b0, 0, 1'b0, "post_rst");

    // Surplus finish while the result waits in OUT.
    do_window({49{8'd4}}, {49{8'd8}}, 8'd6, 1'b1, 6, 1'b1, "out_extra");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("clear_err", 64'(err), 64'd0);
    drain_count("clear");

    // Stray finish in IDLE: err sets and stays through later windows.
    @(negedge clk);
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    chk("idle_inject_err", 64'(err), 64'd1);
    do_window({49{8'd16}}, {49{8'd16}}, 8'd49, 1'b1, 0, 1'b0, "sticky1");
    do_window({49{8'd255}}, {49{8'd255}}, 8'd255, 1'b1, 0, 1'b0, "sticky2");
    rst = 1'b1;
    @(negedge clk);
    chk("final_rst_err", 64'(err), 64'd0);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
